quad_input_filter: RTL and testbench

//  Input conditioner placed directly upstream of encoder_mmio. Synchronises raw quadrature A/B pins

---
 rtl/enc_pkg.sv | 17 +
 rtl/quad_chan_filter.sv | 53 +++++
 rtl/quad_input_filter.sv | 81 ++++++++
 tb/tb_quad_input_filter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared encoder definitions: default widths for the input filter and the
// quadrature state encoding used by both quad_input_filter and encoder_mmio.
package enc_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_W      = 4;
  localparam int DEF_ERR_W       = 8;

  // Forward rotation steps 00 -> 01 -> 11 -> 10 -> 00
  typedef enum logic [1:0] {
    QUAD_S0 = 2'b00,
    QUAD_S1 = 2'b01,
    QUAD_S2 = 2'b11,
    QUAD_S3 = 2'b10
  } quad_state_t;

endpackage

// File: rtl/quad_chan_filter.sv
// One encoder channel: multi-flop synchroniser followed by a stability
// counter that only lets the output follow the pin after filt_thresh+1 stable cycles.
module quad_chan_filter
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [FILT_W-1:0] filt_thresh,
  input  logic              raw,
  output logic              enc,
  output logic              update
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [FILT_W-1:0]      cnt;

  assign synced = sync_q[SYNC_STAGES-1];

  // The synchroniser keeps running while the filter is disabled so the
  // pin state is already settled when qualification restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Exported so the top level can spot both channels moving on the same edge.
  assign update = enable && (synced != enc) && (cnt >= filt_thresh);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      enc <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (synced == enc) begin
      cnt <= '0;
    end else if (update) begin
      enc <= synced;
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/quad_input_filter.sv
// Quadrature input conditioner for encoder_mmio: two filtered channels plus
// illegal double-step detection. Define ENC_FILT_ERR_CNT_EN for the error counter.
module quad_input_filter
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W,
  parameter int ERR_W       = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [FILT_W-1:0] filt_thresh,
  input  logic              raw_a,
  input  logic              raw_b,
  input  logic              err_clr,
  output logic              enc_a,
  output logic              enc_b,
  output logic              illegal,
  output logic [ERR_W-1:0]  err_count
);

  logic update_a;
  logic update_b;
  logic illegal_next;

  quad_chan_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_chan_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .filt_thresh (filt_thresh),
    .raw         (raw_a),
    .enc         (enc_a),
    .update      (update_a)
  );

  quad_chan_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) u_chan_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .filt_thresh (filt_thresh),
    .raw         (raw_b),
    .enc         (enc_b),
    .update      (update_b)
  );

  // A legal quadrature step only ever flips one line at a time.
  assign illegal_next = update_a & update_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal <= 1'b0;
    end else begin
      illegal <= illegal_next;
    end
  end

`ifdef ENC_FILT_ERR_CNT_EN
  // Counts alongside the illegal pulse; a clear request beats an increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (illegal_next && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_quad_input_filter.sv
// Directed scoreboard bench for quad_input_filter: latency, glitch rejection,
// forward rotation, illegal detection, enable hold and async reset.
module tb_quad_input_filter;

  localparam int FILT_W = 4;
  localparam int ERR_W  = 8;

`ifdef ENC_FILT_ERR_CNT_EN
  localparam logic [ERR_W-1:0] ERR_ONE = 8'd1;
`else
  localparam logic [ERR_W-1:0] ERR_ONE = 8'd0;
`endif

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [FILT_W-1:0] filt_thresh;
  logic              raw_a;
  logic              raw_b;
  logic              err_clr;
  logic              enc_a;
  logic              enc_b;
  logic              illegal;
  logic [ERR_W-1:0]  err_count;

  typedef struct {
    string            tag;
    logic             a;
    logic             b;
    logic             ill;
    logic [ERR_W-1:0] err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   ill_cycles = 0;

  quad_input_filter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .filt_thresh (filt_thresh),
    .raw_a       (raw_a),
    .raw_b       (raw_b),
    .err_clr     (err_clr),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .illegal     (illegal),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (illegal === 1'b1) ill_cycles++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic a, input logic b);
    raw_a = a;
    raw_b = b;
  endtask

  task automatic expect_out(input string tag, input logic a, input logic b,
                            input logic ill, input logic [ERR_W-1:0] err);
    exp_t e;
    e.tag = tag;
    e.a   = a;
    e.b   = b;
    e.ill = ill;
    e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({e.tag, ".enc_a"},     {31'd0, enc_a},   {31'd0, e.a});
      check_val({e.tag, ".enc_b"},     {31'd0, enc_b},   {31'd0, e.b});
      check_val({e.tag, ".illegal"},   {31'd0, illegal}, {31'd0, e.ill});
      check_val({e.tag, ".err_count"}, {24'd0, err_count}, {24'd0, e.err});
    end
  endtask

  logic [1:0] fwd_seq [4];

  initial begin
    fwd_seq[0] = 2'b01;
    fwd_seq[1] = 2'b11;
    fwd_seq[2] = 2'b10;
    fwd_seq[3] = 2'b00;

    reset_n     = 1'b0;
    enable      = 1'b0;
    filt_thresh = '0;
    err_clr     = 1'b0;
    apply_stimulus(1'b1, 1'b1);

    #2;
    expect_out("reset_async", 1'b0, 1'b0, 1'b0, '0);
    check_output();
    step(3);
    expect_out("reset_held", 1'b0, 1'b0, 1'b0, '0);
    check_output();

    apply_stimulus(1'b0, 1'b0);
    step(3);
    reset_n     = 1'b1;
    enable      = 1'b1;
    filt_thresh = 4'd3;
    step(4);

    // Latency with threshold 3: the edge appears exactly 6 clocks later
    apply_stimulus(1'b1, 1'b0);
    step(5);
    expect_out("latency_minus1", 1'b0, 1'b0, 1'b0, '0);
    check_output();
    step(1);
    expect_out("latency_exact", 1'b1, 1'b0, 1'b0, '0);
    check_output();
    apply_stimulus(1'b0, 1'b0);
    step(8);
    expect_out("a_fall", 1'b0, 1'b0, 1'b0, '0);
    check_output();

    // A 3-cycle pulse is the longest that threshold 3 rejects
    apply_stimulus(1'b1, 1'b0);
    step(3);
    apply_stimulus(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1);
      expect_out("reject_3cyc", 1'b0, 1'b0, 1'b0, '0);
      check_output();
    end

    // A 4-cycle pulse is just long enough to pass
    apply_stimulus(1'b1, 1'b0);
    step(4);
    apply_stimulus(1'b0, 1'b0);
    step(2);
    expect_out("accept_4cyc", 1'b1, 1'b0, 1'b0, '0);
    check_output();
    step(6);
    expect_out("accept_4cyc_fall", 1'b0, 1'b0, 1'b0, '0);
    check_output();

    // Five forward rotations at threshold 2 never produce an illegal pulse
    filt_thresh = 4'd2;
    for (int c = 0; c < 5; c++) begin
      for (int s = 0; s < 4; s++) begin
        apply_stimulus(fwd_seq[s][1], fwd_seq[s][0]);
        step(8);
        expect_out("forward", fwd_seq[s][1], fwd_seq[s][0], 1'b0, '0);
        check_output();
      end
    end
    check_val("forward_no_illegal", ill_cycles, 32'd0);

    // Both lines flipping together is a one-cycle illegal pulse
    filt_thresh = 4'd1;
    apply_stimulus(1'b1, 1'b1);
    step(3);
    expect_out("dbl_before", 1'b0, 1'b0, 1'b0, '0);
    check_output();
    step(1);
    expect_out("dbl_update", 1'b1, 1'b1, 1'b1, ERR_ONE);
    check_output();
    step(1);
    expect_out("dbl_after", 1'b1, 1'b1, 1'b0, ERR_ONE);
    check_output();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    expect_out("err_clr", 1'b1, 1'b1, 1'b0, '0);
    check_output();
    check_val("illegal_one_cycle", ill_cycles, 32'd1);

    // With the filter disabled the outputs ignore pin activity
    enable      = 1'b0;
    filt_thresh = 4'd3;
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(i[0], i[0]);
      step(3);
      expect_out("disabled_hold", 1'b1, 1'b1, 1'b0, '0);
      check_output();
    end
    apply_stimulus(1'b0, 1'b0);
    step(4);

    // Dropping enable mid-count restarts qualification from zero
    enable = 1'b1;
    step(2);
    enable = 1'b0;
    step(1);
    enable = 1'b1;
    step(3);
    expect_out("reenable_wait", 1'b1, 1'b1, 1'b0, '0);
    check_output();
    step(1);
    expect_out("reenable_update", 1'b0, 1'b0, 1'b1, ERR_ONE);
    check_output();
    step(1);
    check_val("illegal_total", ill_cycles, 32'd2);

    // Reset in the middle of a qualification clears at once and leaves nothing pending
    apply_stimulus(1'b1, 1'b0);
    step(8);
    expect_out("single_a_high", 1'b1, 1'b0, 1'b0, ERR_ONE);
    check_output();
    apply_stimulus(1'b0, 1'b0);
    step(4);
    expect_out("mid_count", 1'b1, 1'b0, 1'b0, ERR_ONE);
    check_output();
    reset_n = 1'b0;
    #1;
    expect_out("async_clear", 1'b0, 1'b0, 1'b0, '0);
    check_output();
    step(2);
    reset_n = 1'b1;
    step(8);
    expect_out("no_pending", 1'b0, 1'b0, 1'b0, '0);
    check_output();
    check_val("scoreboard_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
